// File: rtl/counter_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// counter_ctrl_pkg
// Shared types and constants for the counter command controller.
//   cmd_op_e     : host command encoding (NOP / LOAD / UP / DOWN)
//   ctrl_state_e : controller FSM states
//   DEF_WIDTH    : default counter data width
// -----------------------------------------------------------------------------
package counter_ctrl_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_LOAD = 2'd1,
        OP_UP   = 2'd2,
        OP_DOWN = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_SETTLE = 3'd3,
        ST_RESP   = 3'd4
    } ctrl_state_e;

endpackage : counter_ctrl_pkg

// File: rtl/counter_ref_model.sv
// -----------------------------------------------------------------------------
// counter_ref_model
// Expected-value register mirroring the up/down counter behaviour: load has
// priority over inc/dec, inc/dec wrap modulo 2^WIDTH, reset value is 0.
// Ports:
//   clk     : clock, rising edge
//   reset   : asynchronous active-low reset
//   load_i  : load data_i into the model
//   inc_i   : add one (wrapping)
//   dec_i   : subtract one (wrapping)
//   data_i  : load value
//   value_o : current expected counter value
// -----------------------------------------------------------------------------
module counter_ref_model
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] value_o
);

    logic [WIDTH-1:0] value_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_q <= '0;
        end else if (load_i) begin
            value_q <= data_i;
        end else if (inc_i) begin
            value_q <= value_q + WIDTH'(1);
        end else if (dec_i) begin
            value_q <= value_q - WIDTH'(1);
        end
    end

    assign value_o = value_q;

endmodule : counter_ref_model

// File: rtl/counter_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// counter_cmd_ctrl
// Command-driven controller for the up/down counter. Accepts LOAD/UP/DOWN/NOP
// over valid/ready, drives the counter pins cycle-accurately, reads back the
// counter output and returns it with the expected value and a mismatch flag.
// Ports:
//   clk, reset                 : clock / async active-low reset (shared with counter)
//   cmd_valid/ready/op/arg     : command channel (arg = load value or step count)
//   rsp_valid/ready            : response handshake
//   rsp_value/expected/mismatch: observed value, model value, inequality flag
//   err_cnt                    : saturating count of mismatching responses
//   ctr_data_in/load/enable/up_down : counter control pins
//   ctr_data_out               : counter registered output
// -----------------------------------------------------------------------------
module counter_cmd_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_value,
    output logic [WIDTH-1:0] rsp_expected,
    output logic             rsp_mismatch,
    output logic [ERR_W-1:0] err_cnt,
    output logic [WIDTH-1:0] ctr_data_in,
    output logic             ctr_load,
    output logic             ctr_enable,
    output logic             ctr_up_down,
    input  logic [WIDTH-1:0] ctr_data_out
);

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    ctrl_state_e      state_q;
    logic [WIDTH-1:0] step_q;
    logic             cmd_ready_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_value_q;
    logic [WIDTH-1:0] rsp_expected_q;
    logic             rsp_mismatch_q;
    logic [ERR_W-1:0] err_cnt_q;
    logic [WIDTH-1:0] ctr_data_in_q;
    logic             ctr_load_q;
    logic             ctr_enable_q;
    logic             ctr_up_down_q;

    logic [WIDTH-1:0] exp_value;
    logic             mismatch_d;
    cmd_op_e          op;

    assign op         = cmd_op_e'(cmd_op);
    assign mismatch_d = (ctr_data_out != exp_value);

    // The model follows the same registered control pins the counter samples,
    // so both change on the same edges and agree by construction.
    counter_ref_model #(
        .WIDTH (WIDTH)
    ) u_ref (
        .clk     (clk),
        .reset   (reset),
        .load_i  (ctr_load_q),
        .inc_i   (ctr_enable_q & ctr_up_down_q),
        .dec_i   (ctr_enable_q & ~ctr_up_down_q),
        .data_i  (ctr_data_in_q),
        .value_o (exp_value)
    );

    // Counter controls are registered and set on the edge that enters
    // LOAD/RUN, so they are high exactly while the FSM sits in that state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            step_q         <= '0;
            cmd_ready_q    <= 1'b1;
            rsp_valid_q    <= 1'b0;
            rsp_value_q    <= '0;
            rsp_expected_q <= '0;
            rsp_mismatch_q <= 1'b0;
            err_cnt_q      <= '0;
            ctr_data_in_q  <= '0;
            ctr_load_q     <= 1'b0;
            ctr_enable_q   <= 1'b0;
            ctr_up_down_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        case (op)
                            OP_LOAD: begin
                                state_q       <= ST_LOAD;
                                ctr_load_q    <= 1'b1;
                                ctr_data_in_q <= cmd_arg;
                            end
                            OP_UP, OP_DOWN: begin
                                if (cmd_arg != '0) begin
                                    state_q       <= ST_RUN;
                                    step_q        <= cmd_arg;
                                    ctr_enable_q  <= 1'b1;
                                    ctr_up_down_q <= (op == OP_UP);
                                end else begin
                                    state_q <= ST_SETTLE;
                                end
                            end
                            default: state_q <= ST_SETTLE;
                        endcase
                    end
                end
                ST_LOAD: begin
                    ctr_load_q    <= 1'b0;
                    ctr_data_in_q <= '0;
                    state_q       <= ST_SETTLE;
                end
                ST_RUN: begin
                    step_q <= step_q - WIDTH'(1);
                    if (step_q == WIDTH'(1)) begin
                        ctr_enable_q  <= 1'b0;
                        ctr_up_down_q <= 1'b0;
                        state_q       <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    // Counter output already reflects the last sampled control.
                    rsp_value_q    <= ctr_data_out;
                    rsp_expected_q <= exp_value;
                    rsp_mismatch_q <= mismatch_d;
                    if (mismatch_d) begin
                        err_cnt_q <= sat_inc(err_cnt_q);
                    end
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q       <= ST_IDLE;
                    cmd_ready_q   <= 1'b1;
                    rsp_valid_q   <= 1'b0;
                    ctr_load_q    <= 1'b0;
                    ctr_enable_q  <= 1'b0;
                    ctr_up_down_q <= 1'b0;
                    ctr_data_in_q <= '0;
                end
            endcase
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_value    = rsp_value_q;
    assign rsp_expected = rsp_expected_q;
    assign rsp_mismatch = rsp_mismatch_q;
    assign err_cnt      = err_cnt_q;
    assign ctr_data_in  = ctr_data_in_q;
    assign ctr_load     = ctr_load_q;
    assign ctr_enable   = ctr_enable_q;
    assign ctr_up_down  = ctr_up_down_q;

endmodule : counter_cmd_ctrl

// File: tb/tb_counter_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_counter_cmd_ctrl
// Directed bench for counter_cmd_ctrl with a behavioural up/down counter that
// can be forced to a stuck-at-zero output.
// -----------------------------------------------------------------------------
module tb_counter_cmd_ctrl;

    localparam logic [1:0] NOP  = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] UP   = 2'd2;
    localparam logic [1:0] DOWN = 2'd3;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_arg;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_value;
    logic [7:0] rsp_expected;
    logic       rsp_mismatch;
    logic [7:0] err_cnt;
    logic [7:0] ctr_data_in;
    logic       ctr_load;
    logic       ctr_enable;
    logic       ctr_up_down;
    logic [7:0] ctr_data_out;

    logic [7:0] cnt_q;
    logic       stuck;

    int n_tests = 0;
    int n_fail  = 0;

    counter_cmd_ctrl #(
        .WIDTH (8),
        .ERR_W (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_arg      (cmd_arg),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_value    (rsp_value),
        .rsp_expected (rsp_expected),
        .rsp_mismatch (rsp_mismatch),
        .err_cnt      (err_cnt),
        .ctr_data_in  (ctr_data_in),
        .ctr_load     (ctr_load),
        .ctr_enable   (ctr_enable),
        .ctr_up_down  (ctr_up_down),
        .ctr_data_out (ctr_data_out)
    );

    // Behavioural counter: registered output, load over enable, reset to 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (ctr_load) begin
            cnt_q <= ctr_data_in;
        end else if (ctr_enable) begin
            cnt_q <= ctr_up_down ? cnt_q + 8'd1 : cnt_q - 8'd1;
        end
    end
    assign ctr_data_out = stuck ? 8'h00 : cnt_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic issue(input string tag, input logic [1:0] op, input logic [7:0] arg);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        #1;
        chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_arg   = 8'd0;
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({tag, ".rsp_drop"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".rdy_back"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [7:0] arg,
                           input int e_loads, input int e_ens, input int e_lat,
                           input logic [7:0] e_val, input logic [7:0] e_exp,
                           input logic e_mm, input logic [7:0] e_err, input bit do_consume);
        int loads;
        int ens;
        int bad;
        int lat;
        loads = 0;
        ens   = 0;
        bad   = 0;
        lat   = 0;
        issue(tag, op, arg);
        for (int k = 1; k <= 40; k++) begin
            if (ctr_load) begin
                loads++;
                if (ctr_data_in !== arg) bad++;
            end else if (ctr_data_in !== 8'd0) begin
                bad++;
            end
            if (ctr_enable) begin
                ens++;
                if (ctr_up_down !== (op == UP)) bad++;
            end else if (ctr_up_down !== 1'b0) begin
                bad++;
            end
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        chk({tag, ".latency"}, 32'(lat), 32'(e_lat));
        chk({tag, ".loads"}, 32'(loads), 32'(e_loads));
        chk({tag, ".enables"}, 32'(ens), 32'(e_ens));
        chk({tag, ".ctl_pins"}, 32'(bad), 32'd0);
        chk({tag, ".value"}, 32'(rsp_value), 32'(e_val));
        chk({tag, ".expected"}, 32'(rsp_expected), 32'(e_exp));
        chk({tag, ".mismatch"}, 32'(rsp_mismatch), 32'(e_mm));
        chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(e_err));
        if (do_consume) consume(tag);
    endtask

    initial begin
        logic [7:0] exp_m;
        logic [7:0] err_m;
        logic       mm_m;
        int         seen;

        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_arg   = 8'd0;
        rsp_ready = 1'b0;
        stuck     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rsp_value", 32'(rsp_value), 32'd0);
        chk("rst.rsp_expected", 32'(rsp_expected), 32'd0);
        chk("rst.err_cnt", 32'(err_cnt), 32'd0);
        chk("rst.ctr_pins", 32'({ctr_load, ctr_enable, ctr_up_down, ctr_data_in}), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Basic load, wrap up, wrap down, no-op and zero-step commands
        run_cmd("load5a", LOAD, 8'h5A, 1, 0, 2, 8'h5A, 8'h5A, 1'b0, 8'd0, 1'b1);
        run_cmd("loadfe", LOAD, 8'hFE, 1, 0, 2, 8'hFE, 8'hFE, 1'b0, 8'd0, 1'b1);
        run_cmd("up3",    UP,   8'd3,  0, 3, 4, 8'h01, 8'h01, 1'b0, 8'd0, 1'b1);
        run_cmd("load02", LOAD, 8'h02, 1, 0, 2, 8'h02, 8'h02, 1'b0, 8'd0, 1'b1);
        run_cmd("down5",  DOWN, 8'd5,  0, 5, 6, 8'hFD, 8'hFD, 1'b0, 8'd0, 1'b1);
        run_cmd("nop",    NOP,  8'h44, 0, 0, 1, 8'hFD, 8'hFD, 1'b0, 8'd0, 1'b1);
        run_cmd("up0",    UP,   8'd0,  0, 0, 1, 8'hFD, 8'hFD, 1'b0, 8'd0, 1'b1);
        run_cmd("down0",  DOWN, 8'd0,  0, 0, 1, 8'hFD, 8'hFD, 1'b0, 8'd0, 1'b1);

        // Back-pressure: response held, new command must wait
        run_cmd("hold", LOAD, 8'h77, 1, 0, 2, 8'h77, 8'h77, 1'b0, 8'd0, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = LOAD;
        cmd_arg   = 8'h33;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("hold.rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold.cmd_ready", 32'(cmd_ready), 32'd0);
            chk("hold.rsp_value", 32'(rsp_value), 32'h77);
            chk("hold.rsp_expected", 32'(rsp_expected), 32'h77);
            chk("hold.no_load", 32'(ctr_load), 32'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("hold.released", 32'(rsp_valid), 32'd0);
        chk("hold.ready_back", 32'(cmd_ready), 32'd1);
        chk("hold.not_yet", 32'(ctr_load), 32'd0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_arg   = 8'd0;
        chk("hold.accept_load", 32'(ctr_load), 32'd1);
        chk("hold.accept_data", 32'(ctr_data_in), 32'h33);
        chk("hold.accept_rdy", 32'(cmd_ready), 32'd0);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                seen = 1;
                break;
            end
        end
        chk("hold.rsp_seen", 32'(seen), 32'd1);
        chk("hold.rsp33", 32'(rsp_value), 32'h33);
        consume("hold2");

        // Stuck-at-zero counter: mismatches and err_cnt saturation
        stuck = 1'b1;
        run_cmd("stk.load0", LOAD, 8'h00, 1, 0, 2, 8'h00, 8'h00, 1'b0, 8'd0, 1'b1);
        run_cmd("stk.up4",   UP,   8'd4,  0, 4, 5, 8'h00, 8'h04, 1'b1, 8'd1, 1'b1);
        exp_m = 8'h04;
        err_m = 8'd1;
        for (int i = 2; i <= 300; i++) begin
            exp_m = exp_m + 8'd4;
            mm_m  = (exp_m != 8'h00);
            if (mm_m && err_m != 8'hFF) err_m = err_m + 8'd1;
            run_cmd("sat", UP, 8'd4, 0, 4, 5, 8'h00, exp_m, mm_m, err_m, 1'b1);
        end
        chk("sat.err_cnt", 32'(err_cnt), 32'd255);
        stuck = 1'b0;

        // Reset in the middle of a long UP
        issue("rstmid", UP, 8'd10);
        repeat (3) @(posedge clk);
        #1;
        chk("rstmid.enable_pre", 32'(ctr_enable), 32'd1);
        reset = 1'b0;
        #1;
        chk("rstmid.enable", 32'(ctr_enable), 32'd0);
        chk("rstmid.up_down", 32'(ctr_up_down), 32'd0);
        chk("rstmid.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rstmid.cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rstmid.err_cnt", 32'(err_cnt), 32'd0);
        chk("rstmid.rsp_expected", 32'(rsp_expected), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (rsp_valid || ctr_enable) seen = 1;
        end
        chk("rstmid.quiet", 32'(seen), 32'd0);
        run_cmd("after", LOAD, 8'h10, 1, 0, 2, 8'h10, 8'h10, 1'b0, 8'd0, 1'b1);
        run_cmd("after_up", UP, 8'd2, 0, 2, 3, 8'h12, 8'h12, 1'b0, 8'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_counter_cmd_ctrl

// File: doc/counter_cmd_ctrl.md
# counter_cmd_ctrl

Command-driven controller that initiates all control traffic to the up/down `counter` block. It accepts LOAD / UP / DOWN / NOP commands over a valid/ready handshake, drives the counter's `data_in`/`load`/`enable`/`up_down` pins cycle-accurately, and reads back `data_out`. It also tracks an internal expected value and returns a response carrying the observed value, the expected value and a mismatch flag. It sits between a host or sequencer and the counter, and serves as an in-design self-check of the counter.

## Interface
- `WIDTH`, default 8: counter data width; also the width of the step-count argument.
- `ERR_W`, default 8: width of the saturating error counter.

- `clk`  in  1  system clock; all logic rising-edge.
- `reset`  in  1  asynchronous, active-low reset; shared with the counter.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_op`  in  2  0 NOP, 1 LOAD, 2 UP, 3 DOWN.
- `cmd_arg`  in  WIDTH  LOAD value, or step count for UP/DOWN.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_value`  out  WIDTH  counter `data_out` captured at completion.
- `rsp_expected`  out  WIDTH  model value at completion.
- `rsp_mismatch`  out  1  `rsp_value != rsp_expected`.
- `err_cnt`  out  ERR_W  count of mismatching responses; saturates at all-ones.
- `ctr_data_in`  out  WIDTH  to counter `data_in`.
- `ctr_load`  out  1  to counter `load`.
- `ctr_enable`  out  1  to counter `enable`.
- `ctr_up_down`  out  1  to counter `up_down`; 1 = up, 0 = down.
- `ctr_data_out`  in  WIDTH  from counter `data_out`.

## Operation
- Counter contract:
  - Registered `data_out`.
  - `load` has priority over `enable`.
  - Each sampled `enable` changes the count by ±1, modulo 2^WIDTH.
  - Resets to 0.
- FSM states: IDLE, LOAD, RUN, SETTLE, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On handshake:
    - LOAD goes to LOAD.
    - UP/DOWN with `cmd_arg`>0 goes to RUN; the step counter is set to `cmd_arg`.
    - NOP, or UP/DOWN with `cmd_arg`=0, goes to SETTLE.
- LOAD:
  - `ctr_load`=1 and `ctr_data_in`=arg for exactly one cycle.
  - The model sets expected = arg.
  - Next state is SETTLE.
- RUN:
  - `ctr_enable`=1, `ctr_up_down` set from the op; the step counter decrements each cycle.
  - The model adds or subtracts 1 per cycle, with wrap.
  - Leaves for SETTLE after the last step.
- SETTLE:
  - All counter controls are 0.
  - At the end of the cycle, `ctr_data_out` and the expected value are captured into the rsp registers, `rsp_mismatch` is computed, and `err_cnt` is updated.
  - Next state is RESP.
- RESP:
  - `rsp_valid`=1; response fields are held stable until `rsp_ready`.
  - Then back to IDLE.
- Counter controls are 0 in every state except LOAD/RUN. `ctr_data_in` is 0 outside LOAD.
- `cmd_ready`=0 in every state except IDLE. `cmd_valid` is ignored there; commands are not queued.

## Timing
- Reset values:
  - State IDLE, `cmd_ready`=1, `rsp_valid`=0.
  - `rsp_value`, `rsp_expected`, `rsp_mismatch`, `err_cnt` = 0.
  - All `ctr_*` outputs = 0; expected model = 0.
- Latency, with the command handshake at edge A:
  - LOAD: `rsp_valid` rises after edge A+2.
  - UP/DOWN with n>0: `ctr_enable` is high for exactly n cycles (edges A+1..A+n); `rsp_valid` rises after edge A+n+1.
  - NOP or n=0: `rsp_valid` rises after edge A+1; no counter controls pulse.
- The next command can be accepted in the cycle after the `rsp_valid`&&`rsp_ready` edge. There is no back-to-back bypass.
- Wrap: UP from 2^WIDTH-1 gives 0; DOWN from 0 gives 2^WIDTH-1. Both are modelled the same way.
- `err_cnt` increments in the SETTLE→RESP edge when mismatched, and holds at 2^ERR_W-1.
- Reset asserted mid-command:
  - Immediate asynchronous return to IDLE with all reset values.
  - The in-flight command is dropped and no response is produced.
  - The counter resets together with the controller, so the model stays consistent.

## Structure
- Package `counter_ctrl_pkg`:
  - `cmd_op_e` enum (NOP/LOAD/UP/DOWN).
  - `ctrl_state_e` enum.
  - Default `WIDTH` constant.
- Sub-module `counter_ref_model`: the expected-value register with load/inc/dec and wrap. The FSM and handshakes stay in `counter_cmd_ctrl`.

## Test plan
- Reset, then LOAD 0x5A → `ctr_load` pulses one cycle with `ctr_data_in`=0x5A; `rsp_valid` after A+2; `rsp_value`=`rsp_expected`=0x5A; `rsp_mismatch`=0.
- LOAD 0xFE, then UP 3 → `ctr_enable`/`ctr_up_down`=1 for exactly 3 cycles; rsp 0x01/0x01 (wrap); `err_cnt`=0.
- LOAD 0x02, then DOWN 5 → rsp 0xFD; NOP and UP 0 → no control pulses; rsp 0xFD after A+1.
- Hold `rsp_ready` low 4 cycles during RESP while driving `cmd_valid`=1 → response fields stable, `cmd_ready`=0, command not accepted; accepted only after release.
- Counter stuck-at-0x00 fault injected, UP 4 from 0x00 → `rsp_mismatch`=1 and `err_cnt` 1; 300 such commands with `ERR_W`=8 → `err_cnt` saturates at 255.
- Assert `reset` at the 4th step of UP 10 → controls drop to 0 immediately, no `rsp_valid`; after release, LOAD 0x10 → rsp 0x10, no mismatch.
